// File: rtl/hamming_scorer.sv
// Scores each captured 1024-bit hash by its Hamming distance to TARGET,
// 64 bits per cycle, and keeps the lowest distance seen with its nonce.

module hamming_popcount #(
    parameter int W  = 64,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++)
            count_o = count_o + CW'(bits_i[i]);
    end
endmodule

module hamming_scorer #(
    parameter logic [1023:0] TARGET = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1023:0] hash_i,
    input  logic [255:0]  nonce_i,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          dist_valid_o,
    output logic [10:0]   dist_o,
    output logic          best_update_o,
    output logic [10:0]   best_dist_o,
    output logic [255:0]  best_nonce_o,
    output logic [15:0]   drop_count_o
);
    localparam int CHUNK_W    = 64;
    localparam int NUM_CHUNKS = 16;
    localparam int POP_W      = $clog2(CHUNK_W + 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                               state_q, state_d;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   diff_q;
    logic [255:0]                         nonce_q;
    logic [10:0]                          acc_q;
    logic [3:0]                           chunk_q;
    logic [10:0]                          dist_q;
    logic [10:0]                          best_dist_q;
    logic [255:0]                         best_nonce_q;
    logic [15:0]                          drop_q;
    logic [POP_W-1:0]                     chunk_pop;
    logic [10:0]                          acc_sum;
    logic                                 new_best;

    hamming_popcount #(.W(CHUNK_W)) u_pop (
        .bits_i  (diff_q[chunk_q]),
        .count_o (chunk_pop)
    );

    assign acc_sum  = acc_q + {{(11-POP_W){1'b0}}, chunk_pop};
    // Strict compare: ties leave the earlier record in place.
    assign new_best = (state_q == DONE) && (acc_q < best_dist_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ready_i) state_d = COUNT;
            COUNT:   if (chunk_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            diff_q       <= '0;
            nonce_q      <= '0;
            acc_q        <= '0;
            chunk_q      <= '0;
            dist_q       <= '0;
            best_dist_q  <= 11'h7FF;
            best_nonce_q <= '0;
            drop_q       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (ready_i) begin
                        diff_q  <= hash_i ^ TARGET;
                        nonce_q <= nonce_i;
                        acc_q   <= '0;
                        chunk_q <= '0;
                    end
                end
                COUNT: begin
                    acc_q   <= acc_sum;
                    chunk_q <= chunk_q + 4'd1;
                    if (chunk_q == 4'd15)
                        dist_q <= acc_sum;
                end
                DONE: begin
                    if (new_best) begin
                        best_dist_q  <= acc_q;
                        best_nonce_q <= nonce_q;
                    end
                end
                default: ;
            endcase
            // Pulses arriving while busy are lost; count them, saturating.
            if (state_q != IDLE && ready_i && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign dist_valid_o  = (state_q == DONE);
    assign dist_o        = dist_q;
    assign best_update_o = new_best;
    assign best_dist_o   = best_dist_q;
    assign best_nonce_o  = best_nonce_q;
    assign drop_count_o  = drop_q;
endmodule

// File: tb/tb_hamming_scorer.sv
// Randomized bench for hamming_scorer against a transaction-level model of
// distance, best record and saturating drop count.

module tb_hamming_scorer;
    localparam logic [1023:0] TGT = {16{64'hC3A5_0F96_7E18_B24D}};

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1023:0] hash_i;
    logic [255:0]  nonce_i;
    logic          ready_i;
    logic          busy_o;
    logic          dist_valid_o;
    logic [10:0]   dist_o;
    logic          best_update_o;
    logic [10:0]   best_dist_o;
    logic [255:0]  best_nonce_o;
    logic [15:0]   drop_count_o;

    hamming_scorer #(.TARGET(TGT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .hash_i        (hash_i),
        .nonce_i       (nonce_i),
        .ready_i       (ready_i),
        .busy_o        (busy_o),
        .dist_valid_o  (dist_valid_o),
        .dist_o        (dist_o),
        .best_update_o (best_update_o),
        .best_dist_o   (best_dist_o),
        .best_nonce_o  (best_nonce_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_best;
    logic [255:0] m_nonce;
    int           m_drops;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1023:0] rand_vec();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] rand_nonce();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Hash whose distance to the target is exactly d.
    function automatic logic [1023:0] with_dist(input int d);
        logic [1023:0] v;
        v = '0;
        while ($countones(v) < d) v[$urandom_range(1023, 0)] = 1'b1;
        return v ^ TGT;
    endfunction

    task automatic do_reset;
        rst_i   = 1'b1;
        ready_i = 1'b1;
        hash_i  = rand_vec();
        nonce_i = rand_nonce();
        tick;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", dist_valid_o, 0);
        chk("rst_upd", best_update_o, 0);
        chk("rst_dist", dist_o, 0);
        chk("rst_best", best_dist_o, 11'h7FF);
        chk("rst_bnonce", best_nonce_o, 0);
        chk("rst_drops", drop_count_o, 0);
        rst_i   = 1'b0;
        ready_i = 1'b0;
        tick;
        chk("rst_ready_ignored", busy_o, 0);
        m_best  = 2047;
        m_nonce = '0;
        m_drops = 0;
    endtask

    // Accept h/n in the current cycle; extra[c] raises ready_i in busy cycle c.
    // Returns in the first idle cycle after DONE.
    task automatic score(input logic [1023:0] h, input logic [255:0] n, input logic [17:1] extra);
        int d;
        bit upd;
        int early;
        d     = $countones(h ^ TGT);
        upd   = d < m_best;
        early = 0;
        chk("idle_before", busy_o, 0);
        ready_i = 1'b1;
        hash_i  = h;
        nonce_i = n;
        for (int c = 1; c <= 17; c++) begin
            tick;
            if (c == 1) chk("busy_c1", busy_o, 1);
            if (c < 17 && dist_valid_o) early++;
            if (c == 17) begin
                chk("valid_c17", dist_valid_o, 1);
                chk("dist_c17", dist_o, d);
                chk("upd_c17", best_update_o, upd);
                chk("busy_c17", busy_o, 1);
            end
            ready_i = extra[c];
            hash_i  = rand_vec();
            nonce_i = rand_nonce();
        end
        chk("early_valid", early, 0);
        m_drops += $countones(extra);
        if (m_drops > 65535) m_drops = 65535;
        if (upd) begin
            m_best  = d;
            m_nonce = n;
        end
        tick;
        ready_i = 1'b0;
        chk("busy_c18", busy_o, 0);
        chk("valid_c18", dist_valid_o, 0);
        chk("dist_hold", dist_o, d);
        chk("best_dist", best_dist_o, m_best);
        chk("best_nonce", best_nonce_o, m_nonce);
        chk("drops", drop_count_o, m_drops);
    endtask

    initial begin
        logic [1023:0] top;
        logic [17:1]   ex;
        logic [255:0]  n3;
        int            stray;

        rst_i   = 1'b0;
        ready_i = 1'b0;
        hash_i  = '0;
        nonce_i = '0;
        do_reset;

        // Extreme distances; bit 1023 alone proves the last chunk is counted.
        score(~TGT, 256'hA, '0);
        top = '0;
        top[1023] = 1'b1;
        score(TGT ^ top, 256'hB, '0);
        score(TGT, 256'h1, '0);
        chk("zero_best", best_dist_o, 0);

        // 500, 600, 400 then a tie at 400, back to back.
        do_reset;
        n3 = rand_nonce();
        score(with_dist(500), rand_nonce(), '0);
        score(with_dist(600), rand_nonce(), '0);
        score(with_dist(400), n3, '0);
        score(with_dist(400), rand_nonce(), '0);
        chk("tie_keeps_nonce", best_nonce_o, n3);
        chk("tie_keeps_dist", best_dist_o, 400);

        // Pulses in busy cycles 5 and 17 are dropped.
        do_reset;
        ex = '0;
        ex[5]  = 1'b1;
        ex[17] = 1'b1;
        score(rand_vec(), rand_nonce(), ex);
        chk("drop_two", drop_count_o, 2);

        for (int i = 0; i < 8; i++) begin
            ex = 17'($urandom);
            if ($urandom_range(1, 0) == 1) score(with_dist($urandom_range(520, 480)), rand_nonce(), ex);
            else score(rand_vec(), rand_nonce(), ex);
        end

        // Reset in the middle of COUNT discards the score.
        ready_i = 1'b1;
        hash_i  = TGT;
        nonce_i = 256'h77;
        tick;
        ready_i = 1'b0;
        for (int c = 2; c <= 8; c++) tick;
        do_reset;
        stray = 0;
        for (int c = 0; c < 24; c++) begin
            if (dist_valid_o || busy_o) stray++;
            tick;
        end
        chk("no_valid_after_rst", stray, 0);
        score(with_dist(37), 256'h55, '0);

        // Continuous ready drives the drop counter past saturation.
        for (int i = 0; i < 3856; i++) score(rand_vec(), rand_nonce(), '1);
        chk("drop_saturated", drop_count_o, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
